// File: rtl/writeback_arbiter_if.sv
// Write-back bus bundle: ALU result, LU result handshake, register-bank write port and hazard mask.
// Optional ports retired_count / starve_count exist only when WRITEBACK_ARBITER_COUNT_EN is defined.
interface writeback_arbiter_if #(
  parameter int DEPTH = 4
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [31:0]      alu_data;
  logic             alu_stall;
  logic             lu_valid;
  logic             lu_ready;
  logic [4:0]       lu_rd;
  logic [31:0]      lu_data;
  logic             reg_write;
  logic [4:0]       write_register;
  logic [31:0]      write_data;
  logic [31:0]      pending_mask;
  logic [CNT_W-1:0] queue_count;
`ifdef WRITEBACK_ARBITER_COUNT_EN
  logic [15:0]      retired_count;
  logic [15:0]      starve_count;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data, lu_valid, lu_rd, lu_data,
    input  alu_stall, lu_ready, reg_write, write_register, write_data,
           pending_mask, queue_count
`ifdef WRITEBACK_ARBITER_COUNT_EN
    , input retired_count, starve_count
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lu_valid, lu_rd, lu_data,
    output alu_stall, lu_ready, reg_write, write_register, write_data,
           pending_mask, queue_count
`ifdef WRITEBACK_ARBITER_COUNT_EN
    , output retired_count, starve_count
`endif
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Register-bank write-back arbiter: ALU priority, in-order LU queue with starvation guard.
// Optional retired/starve event counters enabled by WRITEBACK_ARBITER_COUNT_EN.
module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic              clock,
  input logic              reset,
  writeback_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [4:0]       rd_mem_q   [DEPTH];
  logic [4:0]       rd_mem_d   [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];
  logic [31:0]      data_mem_d [DEPTH];
  logic             reg_write_q, reg_write_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;

  logic        empty, full, ready;
  logic        push, pop, starve_force, alu_win;
  logic [31:0] pending;

  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CNT_W'(DEPTH));
    ready        = reset && !full;
    // rd==0 entries complete the handshake but never enter the queue
    push         = bus.lu_valid && ready && (bus.lu_rd != 5'd0);
    starve_force = !empty && (starve_q == STV_W'(STARVE_LIMIT));
    alu_win      = !starve_force && bus.alu_valid && (bus.alu_rd != 5'd0);
    pop          = !empty && !alu_win;
  end

  always_comb begin
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      rd_mem_d[wr_ptr_q]   = bus.lu_rd;
      data_mem_d[wr_ptr_q] = bus.lu_data;
    end

    starve_d = starve_q;
    if (pop || empty)
      starve_d = '0;
    else if (starve_q != STV_W'(STARVE_LIMIT))
      starve_d = starve_q + STV_W'(1);

    reg_write_d = 1'b0;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    if (pop) begin
      reg_write_d = 1'b1;
      wreg_d      = rd_mem_q[rd_ptr_q];
      wdata_d     = data_mem_q[rd_ptr_q];
    end else if (alu_win) begin
      reg_write_d = 1'b1;
      wreg_d      = bus.alu_rd;
      wdata_d     = bus.alu_data;
    end
  end

  // Duplicate destinations stay flagged until the last matching entry leaves
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q)
        pending[rd_mem_q[rd_ptr_q + PTR_W'(i)]] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      starve_q    <= '0;
      reg_write_q <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      starve_q    <= starve_d;
      reg_write_q <= reg_write_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
    end
  end

  // Entry storage needs no reset: only slots inside [rd_ptr, rd_ptr+count) are ever read
  always_ff @(posedge clock) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign bus.alu_stall      = starve_force;
  assign bus.lu_ready       = ready;
  assign bus.reg_write      = reg_write_q;
  assign bus.write_register = wreg_q;
  assign bus.write_data     = wdata_q;
  assign bus.pending_mask   = pending;
  assign bus.queue_count    = count_q;

`ifdef WRITEBACK_ARBITER_COUNT_EN
  logic [15:0] retired_q, retired_d;
  logic [15:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    retired_d    = retired_q + 16'(reg_write_q);
    starve_cnt_d = starve_cnt_q;
    if (starve_force && (starve_cnt_q != 16'hFFFF))
      starve_cnt_d = starve_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      retired_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      retired_q    <= retired_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.retired_count = retired_q;
  assign bus.starve_count  = starve_cnt_q;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: ALU path, LU fill/starvation, drain order, zero register,
// simultaneous push/pop, duplicate destinations and mid-queue reset.
module tb_writeback_arbiter;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  writeback_arbiter_if #(.DEPTH(4)) bus ();

  writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Upstream must never write a register that still has a queued LU result
  always @(posedge clock) begin
    if (reset === 1'b1 && bus.alu_valid && bus.alu_rd != 5'd0 && !bus.alu_stall &&
        bus.pending_mask[bus.alu_rd]) begin
      errors++;
      $error("FAIL waw_hazard rd=%0d pending_mask=%h", bus.alu_rd, bus.pending_mask);
    end
  end

  initial begin
    reset         = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.lu_valid  = 1'b0;
    bus.lu_rd     = '0;
    bus.lu_data   = '0;
    tick();
    tick();
    chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
    chk("rst_write_register", 32'(bus.write_register), 32'd0);
    chk("rst_write_data", bus.write_data, 32'd0);
    chk("rst_queue_count", 32'(bus.queue_count), 32'd0);
    chk("rst_pending", bus.pending_mask, 32'd0);
    chk("rst_alu_stall", 32'(bus.alu_stall), 32'd0);
    chk("rst_lu_ready", 32'(bus.lu_ready), 32'd0);

    reset = 1'b1;
    tick();
    chk("idle_lu_ready", 32'(bus.lu_ready), 32'd1);

    // ALU only
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_data = 32'h1234;
    tick();
    chk("alu_reg_write", 32'(bus.reg_write), 32'd1);
    chk("alu_write_register", 32'(bus.write_register), 32'd8);
    chk("alu_write_data", bus.write_data, 32'h1234);
    bus.alu_valid = 1'b0;
    tick();
    chk("alu_idle_reg_write", 32'(bus.reg_write), 32'd0);
    chk("alu_idle_hold_reg", 32'(bus.write_register), 32'd8);

    // LU fill against a continuously busy ALU
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'hA5A5_0002;
    bus.lu_valid  = 1'b1; bus.lu_rd  = 5'd9; bus.lu_data  = 32'h0000_0900;
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", 32'(bus.lu_ready), 32'd1);
      tick();
      bus.lu_rd   = bus.lu_rd + 5'd1;
      bus.lu_data = bus.lu_data + 32'd1;
    end
    chk("fill_ready_low", 32'(bus.lu_ready), 32'd0);
    chk("fill_count", 32'(bus.queue_count), 32'd4);
    chk("fill_pending", bus.pending_mask, 32'h0000_1E00);
    chk("fill_alu_wins", 32'(bus.write_register), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("starve_not_yet", 32'(bus.alu_stall), 32'd0);
      tick();
    end
    chk("starve_stall", 32'(bus.alu_stall), 32'd1);
    chk("starve_count_full", 32'(bus.queue_count), 32'd4);
    tick();
    chk("starve_pop_we", 32'(bus.reg_write), 32'd1);
    chk("starve_pop_rd", 32'(bus.write_register), 32'd9);
    chk("starve_pop_data", bus.write_data, 32'h0000_0900);
    chk("starve_stall_once", 32'(bus.alu_stall), 32'd0);
    chk("starve_count", 32'(bus.queue_count), 32'd3);
    chk("starve_pending", bus.pending_mask, 32'h0000_1C00);
    chk("fifth_ready", 32'(bus.lu_ready), 32'd1);
    tick();
    chk("fifth_alu_rd", 32'(bus.write_register), 32'd2);
    chk("fifth_count", 32'(bus.queue_count), 32'd4);
    chk("fifth_pending", bus.pending_mask, 32'h0000_3C00);
    bus.alu_valid = 1'b0;
    bus.lu_valid  = 1'b0;
    tick();
    chk("drain_a_rd", 32'(bus.write_register), 32'd10);
    chk("drain_a_data", bus.write_data, 32'h0000_0901);
    chk("drain_a_count", 32'(bus.queue_count), 32'd3);
    tick();
    chk("drain_b_rd", 32'(bus.write_register), 32'd11);
    chk("drain_b_count", 32'(bus.queue_count), 32'd2);
    chk("drain_b_pending", bus.pending_mask, 32'h0000_3000);

    // Simultaneous push and pop
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd14; bus.lu_data = 32'h0000_0E00;
    tick();
    bus.lu_valid = 1'b0;
    chk("pushpop_rd", 32'(bus.write_register), 32'd12);
    chk("pushpop_data", bus.write_data, 32'h0000_0903);
    chk("pushpop_count", 32'(bus.queue_count), 32'd2);
    chk("pushpop_pending", bus.pending_mask, 32'h0000_6000);
    tick();
    chk("pushpop_next_rd", 32'(bus.write_register), 32'd13);
    tick();
    chk("pushpop_last_rd", 32'(bus.write_register), 32'd14);
    chk("pushpop_last_data", bus.write_data, 32'h0000_0E00);
    chk("pushpop_empty", 32'(bus.queue_count), 32'd0);
    chk("pushpop_pending_clr", bus.pending_mask, 32'd0);
    tick();
    chk("empty_no_write", 32'(bus.reg_write), 32'd0);
    chk("empty_hold_data", bus.write_data, 32'h0000_0E00);

    // Zero register on both paths
    bus.lu_valid  = 1'b1; bus.lu_rd  = 5'd0; bus.lu_data  = 32'hDEAD;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hBEEF;
    chk("zero_ready", 32'(bus.lu_ready), 32'd1);
    tick();
    bus.lu_valid = 1'b0; bus.alu_valid = 1'b0;
    chk("zero_no_write", 32'(bus.reg_write), 32'd0);
    chk("zero_count", 32'(bus.queue_count), 32'd0);
    chk("zero_pending", bus.pending_mask, 32'd0);
    tick();
    chk("zero_still_idle", 32'(bus.reg_write), 32'd0);

    // Duplicate destinations
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2;
    bus.lu_valid  = 1'b1; bus.lu_rd  = 5'd5; bus.lu_data = 32'h0000_0500;
    tick();
    bus.lu_data = 32'h0000_0501;
    tick();
    bus.alu_valid = 1'b0; bus.lu_valid = 1'b0;
    chk("dup_count", 32'(bus.queue_count), 32'd2);
    chk("dup_pending", bus.pending_mask, 32'h0000_0020);
    tick();
    chk("dup_first_data", bus.write_data, 32'h0000_0500);
    chk("dup_pending_kept", bus.pending_mask, 32'h0000_0020);
    tick();
    chk("dup_second_data", bus.write_data, 32'h0000_0501);
    chk("dup_pending_clr", bus.pending_mask, 32'd0);

    // Drain order 9,10,11
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2;
    bus.lu_valid  = 1'b1; bus.lu_rd  = 5'd9; bus.lu_data = 32'h0000_1900;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.lu_rd   = bus.lu_rd + 5'd1;
      bus.lu_data = bus.lu_data + 32'd1;
    end
    bus.alu_valid = 1'b0; bus.lu_valid = 1'b0;
    chk("order_count", 32'(bus.queue_count), 32'd3);
    chk("order_pending", bus.pending_mask, 32'h0000_0E00);
    tick();
    chk("order_rd9", 32'(bus.write_register), 32'd9);
    chk("order_count2", 32'(bus.queue_count), 32'd2);
    chk("order_pending2", bus.pending_mask, 32'h0000_0C00);
    tick();
    chk("order_rd10", 32'(bus.write_register), 32'd10);
    chk("order_count1", 32'(bus.queue_count), 32'd1);
    chk("order_pending1", bus.pending_mask, 32'h0000_0800);
    tick();
    chk("order_rd11", 32'(bus.write_register), 32'd11);
    chk("order_data11", bus.write_data, 32'h0000_1902);
    chk("order_count0", 32'(bus.queue_count), 32'd0);

    // Reset with three entries queued
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2;
    bus.lu_valid  = 1'b1; bus.lu_rd  = 5'd9; bus.lu_data = 32'h0000_2900;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.lu_rd = bus.lu_rd + 5'd1;
    end
    bus.alu_valid = 1'b0; bus.lu_valid = 1'b0;
    chk("prereset_count", 32'(bus.queue_count), 32'd3);
    reset = 1'b0;
    tick();
    chk("midrst_count", 32'(bus.queue_count), 32'd0);
    chk("midrst_pending", bus.pending_mask, 32'd0);
    chk("midrst_reg_write", 32'(bus.reg_write), 32'd0);
    chk("midrst_lu_ready", 32'(bus.lu_ready), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_no_write", 32'(bus.reg_write), 32'd0);
      chk("postrst_count", 32'(bus.queue_count), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
